// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store memory controller with optional split misaligned accesses
module lsu_mem_ctrl #(
   parameter int ADDR_W        = 12,
   parameter int RD_LAT        = 1,
   parameter int MISALIGN_MODE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   localparam int WA_W = ADDR_W - 2;

   typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              cross_q, cross_d;
   logic              err_q, err_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [31:0]       word0_q, word0_d;
   logic [31:0]       word1_q, word1_d;

   logic              req_illegal, req_misal, req_cross;
   logic              wait_done;
   logic [1:0]        off;
   logic [3:0]        mask4;
   logic [7:0]        be_wide;
   logic [31:0]       st_data;
   logic [63:0]       wd_wide;
   logic [31:0]       rd_pair;
   logic [31:0]       ld_data;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:ADDR_W];
   assign off              = addr_q[1:0];
   assign wait_done        = (cnt_q == 2'(RD_LAT - 1));

   always_comb begin
      req_illegal = req_we ? (req_funct3 > 3'b010)
                           : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
      req_misal = 1'b0;
      req_cross = 1'b0;
      case (req_funct3[1:0])
         2'b01: begin
            req_misal = req_addr[0];
            req_cross = (req_addr[1:0] == 2'b11);
         end
         2'b10: begin
            req_misal = (req_addr[1:0] != 2'b00);
            req_cross = req_misal;
         end
         default: ;
      endcase
   end

   // Lane steering: 64-bit views cover both words of a crossing access
   always_comb begin
      case (f3_q[1:0])
         2'b00: begin
            mask4   = 4'b0001;
            st_data = {24'b0, wdata_q[7:0]};
         end
         2'b01: begin
            mask4   = 4'b0011;
            st_data = {16'b0, wdata_q[15:0]};
         end
         default: begin
            mask4   = 4'b1111;
            st_data = wdata_q;
         end
      endcase
      be_wide = {4'b0, mask4} << off;
      wd_wide = {32'b0, st_data} << {off, 3'b000};
      rd_pair = 32'({word1_q, word0_q} >> {off, 3'b000});
      case (f3_q)
         3'b000:  ld_data = {{24{rd_pair[7]}}, rd_pair[7:0]};
         3'b001:  ld_data = {{16{rd_pair[15]}}, rd_pair[15:0]};
         3'b010:  ld_data = rd_pair;
         3'b100:  ld_data = {24'b0, rd_pair[7:0]};
         3'b101:  ld_data = {16'b0, rd_pair[15:0]};
         default: ld_data = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cross_d = cross_q;
      err_d   = err_q;
      cnt_d   = '0;
      word0_d = word0_q;
      word1_d = word1_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr[ADDR_W-1:0];
               wdata_d = req_wdata;
               err_d   = req_illegal || ((MISALIGN_MODE == 0) && req_misal);
               cross_d = req_cross;
               word0_d = '0;
               word1_d = '0;
               state_d = err_d ? RESP : ACC0;
            end
         end
         ACC0:  state_d = !we_q ? WAIT0 : (cross_q ? ACC1 : RESP);
         WAIT0: begin
            if (wait_done) begin
               word0_d = mem_rdata;
               state_d = cross_q ? ACC1 : RESP;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         ACC1:  state_d = we_q ? RESP : WAIT1;
         WAIT1: begin
            if (wait_done) begin
               word1_d = mem_rdata;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      rsp_err   = rsp_valid && err_q;
      rsp_rdata = (rsp_valid && !err_q && !we_q) ? ld_data : '0;
      mem_en    = (state_q == ACC0) || (state_q == ACC1);
      mem_we    = mem_en && we_q;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      if (state_q == ACC0) begin
         mem_addr  = addr_q[ADDR_W-1:2];
         mem_be    = be_wide[3:0];
         mem_wdata = we_q ? wd_wide[31:0] : '0;
      end else if (state_q == ACC1) begin
         mem_addr  = addr_q[ADDR_W-1:2] + WA_W'(1);
         mem_be    = be_wide[7:4];
         mem_wdata = we_q ? wd_wide[63:32] : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cross_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         word0_q <= '0;
         word1_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cross_q <= cross_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         word0_q <= word0_d;
         word1_q <= word1_d;
      end
   end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench: instance 0 splits misaligned (RD_LAT=1), instance 1 traps them (RD_LAT=2)
module tb_lsu_mem_ctrl;
   localparam int LAT0 = 1;
   localparam int LAT1 = 2;

   typedef struct {
      logic        we;
      logic [9:0]  addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } acc_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          t0;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [9:0]  mem_addr  [2];
   logic [3:0]  mem_be    [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];

   logic [31:0] mem_w [2][1024];
   logic [31:0] rpipe [2][4];
   logic [7:0]  ref_b [2][4096];
   bit          mem_loaded = 1'b0;

   acc_t acc_q [$];
   rsp_t rsp_q [$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.ADDR_W(12), .RD_LAT(LAT0), .MISALIGN_MODE(1)) u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_be(mem_be[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
   );

   lsu_mem_ctrl #(.ADDR_W(12), .RD_LAT(LAT1), .MISALIGN_MODE(0)) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_be(mem_be[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 0)    return 32'h8011_2233;
      if (i == 1023) return 32'hAABB_CCDD;
      return (32'h0102_0304 * 32'(i + 1)) ^ 32'hA55A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Word memory with a read pipeline; read data appears LATk cycles after mem_en
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < 1024; i++) mem_w[k][i] = init_word(i);
         mem_loaded = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
         for (int j = 3; j > 0; j--) rpipe[k][j] <= rpipe[k][j-1];
         rpipe[k][0] <= (mem_en[k] && !mem_we[k]) ? mem_w[k][mem_addr[k]] : 32'hDEAD_BEEF;
         if (mem_en[k] && mem_we[k])
            for (int l = 0; l < 4; l++)
               if (mem_be[k][l]) mem_w[k][mem_addr[k]][8*l +: 8] = mem_wdata[k][8*l +: 8];
      end
   end
   assign mem_rdata[0] = rpipe[0][LAT0-1];
   assign mem_rdata[1] = rpipe[1][LAT1-1];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      acc_t a;
      rsp_t r;
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            if (mem_en[k]) begin
               chk("acc_pending", 64'(acc_q.size() != 0), 64'd1);
               if (acc_q.size() != 0) begin
                  a = acc_q.pop_front();
                  chk("mem_we", 64'(mem_we[k]), 64'(a.we));
                  chk("mem_addr", 64'(mem_addr[k]), 64'(a.addr));
                  chk("mem_be", 64'(mem_be[k]), 64'(a.be));
                  chk("mem_wdata", 64'(mem_wdata[k]), 64'(a.wdata));
               end
            end else begin
               chk("bus_idle", 64'({mem_we[k], mem_addr[k], mem_be[k], mem_wdata[k]}), 64'd0);
            end
            if (rsp_valid[k]) begin
               chk("rsp_pending", 64'(rsp_q.size() != 0), 64'd1);
               if (rsp_q.size() != 0) begin
                  r = rsp_q.pop_front();
                  chk("rsp_rdata", 64'(rsp_rdata[k]), 64'(r.rdata));
                  chk("rsp_err", 64'(rsp_err[k]), 64'(r.err));
                  chk("rsp_latency", 64'(cyc - r.t0 + 1), 64'(r.lat));
               end
            end else begin
               chk("rsp_idle", 64'({rsp_err[k], rsp_rdata[k]}), 64'd0);
            end
         end
      end
   end

   // Byte-wise reference: walk each byte of the access and group bytes by word
   task automatic do_req(input int k, input bit we, input bit [2:0] f3,
                         input bit [31:0] addr, input bit [31:0] wd);
      int          s, o, b, lane, nacc, lat, n, lt;
      bit          err;
      logic [31:0] val;
      acc_t        acc [2];
      rsp_t        r;
      s   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      o   = int'(addr[1:0]);
      err = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      if (k == 1 && (o % s) != 0) err = 1'b1;
      nacc = 0;
      val  = '0;
      for (int i = 0; i < 2; i++) begin
         acc[i].we = we; acc[i].addr = '0; acc[i].be = '0; acc[i].wdata = '0;
      end
      if (!err) begin
         for (int i = 0; i < s; i++) begin
            b    = int'({20'b0, addr[11:0] + 12'(i)});
            lane = b % 4;
            if (nacc == 0 || acc[nacc-1].addr != 10'(b >> 2)) begin
               acc[nacc].addr = 10'(b >> 2);
               nacc++;
            end
            acc[nacc-1].be[lane] = 1'b1;
            if (we) begin
               acc[nacc-1].wdata[8*lane +: 8] = wd[8*i +: 8];
               ref_b[k][b] = wd[8*i +: 8];
            end else begin
               val = val | (32'(ref_b[k][b]) << (8*i));
            end
         end
         if (f3 == 3'b000) val = {{24{val[7]}}, val[7:0]};
         if (f3 == 3'b001) val = {{16{val[15]}}, val[15:0]};
      end
      lt  = (k == 0) ? LAT0 : LAT1;
      lat = err ? 1 : we ? ((nacc == 2) ? 3 : 2) : ((nacc == 2) ? 3 + 2*lt : 2 + lt);
      r.rdata = (err || we) ? 32'd0 : val;
      r.err   = err;
      r.lat   = lat;

      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      req_valid[k] = 1'b1;
      n = 0;
      while (!req_ready[k] && n < 20) begin @(negedge clk); n++; end
      chk("req_ready", 64'(req_ready[k]), 64'd1);
      @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
      r.t0 = cyc;
      for (int i = 0; i < nacc; i++) acc_q.push_back(acc[i]);
      rsp_q.push_back(r);
      n = 0;
      while (rsp_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
      chk("rsp_wait", 64'(rsp_q.size()), 64'd0);
      chk("acc_left", 64'(acc_q.size()), 64'd0);
      rsp_q.delete();
      acc_q.delete();
   endtask

   initial begin
      logic [31:0] w;
      rst = 1'b1;
      req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 1024; i++) begin
            w = init_word(i);
            for (int l = 0; l < 4; l++) ref_b[k][4*i + l] = w[8*l +: 8];
         end

      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({rsp_valid[0], rsp_err[0], rsp_rdata[0], mem_en[0], mem_we[0], mem_be[0]}), 64'd0);
      chk("reset_bus", 64'({mem_addr[0], mem_wdata[0]}), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_ready", 64'({req_ready[0], req_ready[1]}), 64'd3);

      do_req(0, 1'b0, 3'b000, 32'h0000_0003, 32'h0);
      do_req(0, 1'b0, 3'b100, 32'h0000_0003, 32'h0);
      do_req(0, 1'b1, 3'b001, 32'h0000_0002, 32'h0000_ABCD);
      do_req(0, 1'b0, 3'b001, 32'h0000_0002, 32'h0);
      do_req(0, 1'b0, 3'b101, 32'h0000_0002, 32'h0);
      do_req(0, 1'b1, 3'b010, 32'h0000_0005, 32'h1122_3344);
      do_req(0, 1'b0, 3'b010, 32'h0000_0005, 32'h0);
      do_req(0, 1'b0, 3'b010, 32'h0000_0FFE, 32'h0);
      do_req(0, 1'b1, 3'b000, 32'hF000_0007, 32'hDEAD_BE5A);
      do_req(0, 1'b0, 3'b001, 32'h0000_0003, 32'h0);
      do_req(0, 1'b0, 3'b001, 32'h0000_0001, 32'h0);
      do_req(0, 1'b1, 3'b001, 32'h0000_0FFF, 32'h1234_ABCD);
      do_req(0, 1'b0, 3'b101, 32'h0000_0FFF, 32'h0);
      do_req(0, 1'b1, 3'b100, 32'h0000_0010, 32'h5555_5555);
      do_req(0, 1'b0, 3'b110, 32'h0000_0010, 32'h0);

      do_req(1, 1'b0, 3'b001, 32'h0000_0001, 32'h0);
      do_req(1, 1'b0, 3'b011, 32'h0000_0000, 32'h0);
      do_req(1, 1'b0, 3'b010, 32'h0000_0000, 32'h0);
      do_req(1, 1'b1, 3'b010, 32'h0000_0006, 32'h7777_8888);
      do_req(1, 1'b1, 3'b001, 32'h0000_0006, 32'h9999_8001);
      do_req(1, 1'b0, 3'b001, 32'h0000_0006, 32'h0);
      do_req(1, 1'b0, 3'b000, 32'h0000_0003, 32'h0);

      // Abort a load while it waits for read data
      @(negedge clk);
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0010; req_wdata = '0;
      req_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      begin
         acc_t a;
         a.we = 1'b0; a.addr = 10'h004; a.be = 4'hF; a.wdata = '0;
         acc_q.push_back(a);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_mem_en", 64'({mem_en[0], mem_be[0], mem_addr[0]}), 64'd0);
      chk("abort_rsp", 64'({rsp_valid[0], rsp_err[0], rsp_rdata[0]}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_ready", 64'(req_ready[0]), 64'd1);
      repeat (8) @(negedge clk);
      chk("abort_acc_left", 64'(acc_q.size()), 64'd0);
      acc_q.delete();

      for (int t = 0; t < 24; t++)
         do_req(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom());
      for (int t = 0; t < 12; t++)
         do_req(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom());

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 Parameter ADDR_W, default 12, SHALL set the byte-address width used; the word address is ADDR_W-2 bits.
REQ-003 Parameter RD_LAT, default 1, legal 1..4, SHALL set the memory read latency in cycles from mem_en to valid mem_rdata.
REQ-004 Parameter MISALIGN_MODE, default 1, SHALL select misalignment handling: 0 = misaligned access reports an error; 1 = misaligned access is executed.
REQ-005 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address; bits above ADDR_W-1 ignored
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  single-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  illegal funct3, or misaligned with MISALIGN_MODE=0
- mem_en  out  1  memory access strobe
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W-2  word address
- mem_be  out  4  byte-lane enables
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  read word, RD_LAT cycles after mem_en

Function
REQ-006 req_ready SHALL be 1 only in state IDLE; a request is accepted on a clk edge with req_valid&&req_ready, and its fields SHALL be latched.
REQ-007 FSM states SHALL be IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP, with these transitions:
- IDLE -> ACC0 on accept.
- ACC0 -> WAIT0, or -> ACC1 for a split store, or -> RESP for a single store.
- WAIT0 -> ACC1 for a split load, else -> RESP.
- ACC1 -> WAIT1 for a load, else -> RESP.
- WAIT1 -> RESP.
- RESP -> IDLE.
REQ-008 mem_en SHALL be 1 for exactly one cycle in each ACCx state and 0 otherwise; mem_we = req_we in those cycles, else 0.
REQ-009 WAITx SHALL last RD_LAT cycles via a counter; mem_rdata SHALL be captured on the last WAITx cycle.
REQ-010 Offset o = req_addr[1:0], size s = 1/2/4 bytes; the access is misaligned when o mod s != 0, and crossing when o+s > 4.
REQ-011 Illegal funct3 (loads: 011, 110, 111; stores: > 010) SHALL go IDLE -> RESP with rsp_err=1 and no mem_en.
REQ-012 With MISALIGN_MODE=0, a misaligned access SHALL go IDLE -> RESP with rsp_err=1 and no mem_en.
REQ-013 With MISALIGN_MODE=1, a non-crossing access SHALL use one access (ACC0). A crossing access SHALL use two accesses: ACC0 at word W, ACC1 at W+1 modulo 2^(ADDR_W-2).
REQ-014 Let mask = (2^s)-1. Then:
- ACC0: mem_be = (mask<<o)[3:0], mem_wdata = (req_wdata<<8o)[31:0].
- ACC1: mem_be = (mask<<o)[7:4], mem_wdata = req_wdata>>(8(4-o)).
- Non-store-data bits of mem_wdata SHALL be 0.
REQ-015 Load result SHALL be ({word1,word0}>>8o) truncated to s bytes; word1 = 0 when not crossing. It SHALL be sign-extended for B/H and zero-extended for BU/HU.
REQ-016 rsp_valid SHALL be 1 only in RESP. rsp_rdata and rsp_err SHALL be valid with it and hold 0 at all other times.
REQ-017 Latency from accept edge to rsp_valid SHALL be:
- aligned/non-crossing load: 2+RD_LAT cycles;
- store: 2;
- crossing load: 3+2*RD_LAT;
- crossing store: 3;
- error: 1.
REQ-018 mem_addr, mem_be and mem_wdata SHALL be 0 when mem_en=0.

Reset
REQ-019 rst SHALL immediately force state IDLE and force all outputs to 0, except req_ready; req_ready SHALL be 1 after rst deasserts.
REQ-020 rst during any non-IDLE state SHALL abort the transaction; no rsp_valid SHALL follow and no further mem_en SHALL be issued.

Verification (RD_LAT=1, ADDR_W=12 unless stated)
REQ-021 Load LB at 0x003 with mem word 0x80112233 -> mem_addr 0x000, rsp_rdata 0xFFFFFF80 three cycles after accept; LBU -> 0x00000080.
REQ-022 Store SH of 0x0000ABCD at 0x002 -> mem_be 1100, mem_wdata 0xABCD0000, mem_we=1, rsp_valid two cycles after accept.
REQ-023 MISALIGN_MODE=1, SW of 0x11223344 at 0x005 -> ACC0 at word 1 with be 1110, wdata 0x22334400; ACC1 at word 2 with be 0001, wdata 0x00000011; LW at 0x005 then returns 0x11223344 at cycle 5.
REQ-024 MISALIGN_MODE=0, LH at 0x001 -> rsp_err=1, rsp_rdata=0 one cycle after accept, mem_en never 1; funct3 011 load -> same result.
REQ-025 MISALIGN_MODE=1, LW at 0xFFE -> word accesses 0x3FF then 0x000 (wrap); result = {word0[15:0], word3FF[31:16]}.
REQ-026 rst pulsed in WAIT0 of a load -> mem_en and rsp_valid 0 at once, no rsp_valid afterwards, and req_ready=1 on the first edge after release.
